// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Package : game_pkg
// Shared phase encoding, display-word field layout and 7-segment glyphs.
// Rev     : 1.0
// ============================================================================
package game_pkg;

    typedef enum logic [1:0] {
        PH_IDLE      = 2'd0,
        PH_COUNTDOWN = 2'd1,
        PH_PLAY      = 2'd2,
        PH_OVER      = 2'd3
    } phase_e;

    // Display word layout: {dig, seg1, seg2, led}, one byte each
    localparam int FIELD_W  = 8;
    localparam int DIG_MSB  = 31;
    localparam int SEG1_MSB = 23;
    localparam int SEG2_MSB = 15;
    localparam int LED_MSB  = 7;

    // Active-low common-anode glyphs, bit order {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;

    function automatic logic [FIELD_W-1:0] disp_field(
        input logic [31:0] word,
        input int          msb
    );
        return word[msb -: FIELD_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sec_tick_gen.sv
`default_nettype none
// ============================================================================
// Module : sec_tick_gen
// Free-running divider producing a one-cycle tick every TICK_DIV enabled cycles.
// Rev    : 1.0
// ============================================================================
module sec_tick_gen #(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int             CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module : game_flow_ctrl
// Whack-a-mole round sequencer with phase timing and board display mux.
// Rev    : 1.0
// ============================================================================
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int TICK_DIV     = 100000000,
    parameter int PLAY_SECONDS = 30,
    parameter int OVER_SECONDS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_btn,
    input  logic        abort_btn,
    input  logic        count_down_game,
    input  logic [31:0] disp_idle,
    input  logic [31:0] disp_cd,
    input  logic [31:0] disp_play,
    input  logic [31:0] disp_over,
    output logic        ready_game,
    output logic        play_en,
    output logic        game_over,
    output logic        round_rst,
    output logic [1:0]  phase,
    output logic [7:0]  time_left,
    output logic [7:0]  dig_display,
    output logic [7:0]  seg_code_1,
    output logic [7:0]  seg_code_2,
    output logic [7:0]  state_led_show
);

    localparam logic [7:0] PLAY_INIT = 8'(PLAY_SECONDS);
    localparam logic [7:0] OVER_LAST = 8'(OVER_SECONDS - 1);

    phase_e      phase_q;
    phase_e      phase_d;
    logic        start_q;
    logic        start_rise;
    logic        tick;
    logic        tick_clr;
    logic        tick_en;
    logic [7:0]  time_left_q;
    logic [7:0]  time_left_d;
    logic [7:0]  over_cnt_q;
    logic [7:0]  over_cnt_d;
    logic        ready_q,     ready_d;
    logic        play_en_q,   play_en_d;
    logic        game_over_q, game_over_d;
    logic        round_rst_q, round_rst_d;
    logic [31:0] sel_word;
    logic [7:0]  dig_q, seg1_q, seg2_q, led_q;

    // start_q resets high so a button held through reset is not a press
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= 1'b1;
        end else begin
            start_q <= start_btn;
        end
    end

    assign start_rise = start_btn & ~start_q;

    assign tick_clr = (phase_d != phase_q);
    assign tick_en  = (phase_q == PH_PLAY) || (phase_q == PH_OVER);

    sec_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_sec_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .en   (tick_en),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_IDLE;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_IDLE: begin
                if (start_rise) begin
                    phase_d = PH_COUNTDOWN;
                end
            end
            PH_COUNTDOWN: begin
                if (abort_btn) begin
                    phase_d = PH_IDLE;
                end else if (count_down_game) begin
                    phase_d = PH_PLAY;
                end
            end
            PH_PLAY: begin
                if ((tick && time_left_q == 8'd1) || abort_btn) begin
                    phase_d = PH_OVER;
                end
            end
            PH_OVER: begin
                if (tick && over_cnt_q == OVER_LAST) begin
                    phase_d = PH_IDLE;
                end
            end
            default: phase_d = PH_IDLE;
        endcase
    end

    // Status levels follow the next phase so they switch with the phase register
    always_comb begin
        ready_d     = (phase_d == PH_COUNTDOWN);
        play_en_d   = (phase_d == PH_PLAY);
        game_over_d = (phase_d == PH_OVER);
        round_rst_d = (phase_d == PH_IDLE) &&
                      ((phase_q == PH_COUNTDOWN) || (phase_q == PH_OVER));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q     <= 1'b0;
            play_en_q   <= 1'b0;
            game_over_q <= 1'b0;
            round_rst_q <= 1'b0;
        end else begin
            ready_q     <= ready_d;
            play_en_q   <= play_en_d;
            game_over_q <= game_over_d;
            round_rst_q <= round_rst_d;
        end
    end

    // An abort freezes the count unless it coincides with the final tick
    always_comb begin
        time_left_d = time_left_q;
        if (phase_d == PH_IDLE || phase_q == PH_COUNTDOWN) begin
            time_left_d = PLAY_INIT;
        end else if (phase_q == PH_PLAY && tick &&
                     (time_left_q == 8'd1 || !abort_btn)) begin
            time_left_d = time_left_q - 8'd1;
        end
    end

    always_comb begin
        over_cnt_d = over_cnt_q;
        if (phase_q != PH_OVER || phase_d != PH_OVER) begin
            over_cnt_d = '0;
        end else if (tick) begin
            over_cnt_d = over_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            time_left_q <= PLAY_INIT;
            over_cnt_q  <= '0;
        end else begin
            time_left_q <= time_left_d;
            over_cnt_q  <= over_cnt_d;
        end
    end

    always_comb begin
        sel_word = disp_idle;
        case (phase_q)
            PH_IDLE:      sel_word = disp_idle;
            PH_COUNTDOWN: sel_word = disp_cd;
            PH_PLAY:      sel_word = disp_play;
            PH_OVER:      sel_word = disp_over;
            default:      sel_word = disp_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dig_q  <= '0;
            seg1_q <= '0;
            seg2_q <= '0;
            led_q  <= '0;
        end else begin
            dig_q  <= disp_field(sel_word, DIG_MSB);
            seg1_q <= disp_field(sel_word, SEG1_MSB);
            seg2_q <= disp_field(sel_word, SEG2_MSB);
            led_q  <= disp_field(sel_word, LED_MSB);
        end
    end

    assign phase          = phase_q;
    assign time_left      = time_left_q;
    assign ready_game     = ready_q;
    assign play_en        = play_en_q;
    assign game_over      = game_over_q;
    assign round_rst      = round_rst_q;
    assign dig_display    = dig_q;
    assign seg_code_1     = seg1_q;
    assign seg_code_2     = seg2_q;
    assign state_led_show = led_q;

endmodule
`default_nettype wire
